seg_scan_display: RTL



---
 rtl/seg_scan_display_pkg.sv | 33 +++
 rtl/seg_scan_display_hex_to_seg7.sv | 11 +
 rtl/seg_scan_display.sv | 97 +++++++++
 3 files changed

// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the multiplexed seven-segment display: digit count,
// blank patterns and the active-low hex glyph table ({g,f,e,d,c,b,a}).
package seg_scan_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = 8'hFF;
  localparam logic [SEG_W-1:0]      SEG_OFF = 7'h7F;

  // Entry n sits at HEX_SEG[n]; listed from F down to 0.
  localparam logic [15:0][SEG_W-1:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_scan_display_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph.
module hex_to_seg7
  import seg_scan_display_pkg::*;
(
  input  logic [NIB_W-1:0] nibble_i,
  output logic [SEG_W-1:0] seg_c_o
);

  assign seg_c_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg_scan_display.sv
// 8-digit time-multiplexed hex display with frame-boundary shadow register,
// optional leading-zero blanking and a sticky halt freeze.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned CNT_W   = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           data_in,
  input  logic                  hault,
  input  logic                  lz_blank,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  halted
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [31:0]           shadow_q, shadow_d;
  logic                  halt_seen_q, halt_seen_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  tick;
  logic                  frame_end;
  logic [4:0]            bit_base;
  logic [NIB_W-1:0]      cur_nibble;
  logic [SEG_W-1:0]      cur_seg_c;
  logic                  upper_zero;

  assign tick       = (div_cnt_q == DIV_LAST);
  assign frame_end  = tick && (idx_q == IDX_LAST);
  assign bit_base   = {idx_q, 2'b00};
  assign cur_nibble = shadow_q[bit_base +: NIB_W];
  // True when this nibble and every more-significant one are zero.
  assign upper_zero = ((shadow_q >> bit_base) == 32'h0);

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (cur_nibble),
    .seg_c_o  (cur_seg_c)
  );

  always_comb begin
    div_cnt_d   = div_cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    halt_seen_d = halt_seen_q | hault;
    an_d        = ~(NUM_DIGITS'(1) << idx_q);
    seg_d       = cur_seg_c;
    dp_d        = ~halt_seen_q;

    if (tick) begin
      div_cnt_d = '0;
      idx_d     = idx_q + IDX_W'(1);
    end
    // A halt in the boundary cycle itself wins over the reload.
    if (frame_end && !halt_seen_q && !hault) begin
      shadow_d = data_in;
    end
    if (lz_blank && (idx_q != '0) && upper_zero) begin
      an_d = AN_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q   <= '0;
      idx_q       <= '0;
      shadow_q    <= 32'h0;
      halt_seen_q <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      halt_seen_q <= halt_seen_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign dp     = dp_q;
  assign halted = halt_seen_q;

endmodule
